// File: rtl/asynfifo_err_report_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// asynfifo_err_report_arbiter_pkg
// Shared constants, FSM state type and helpers for the async-FIFO error
// report path.
//   PORT_NUM   : sources per error type (0 = host, 1..8 = p0..p7)
//   SRC_NUM    : total (port, type) sources, source s = port*3 + (type-1)
//   ERR_TYPE_* : report type codes carried on ov_report_type
// ---------------------------------------------------------------------------
package asynfifo_err_report_arbiter_pkg;

    localparam int PORT_NUM = 9;
    localparam int SRC_NUM  = 3 * PORT_NUM;

    localparam logic [1:0] ERR_TYPE_RX_OVF = 2'd1;
    localparam logic [1:0] ERR_TYPE_RX_UDF = 2'd2;
    localparam logic [1:0] ERR_TYPE_TX_OVF = 2'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPORT = 1'b1
    } rpt_state_e;

    // Port index of a flat source number.
    function automatic logic [3:0] src_port(input int src);
        int p;
        p = src / 3;
        return p[3:0];
    endfunction

    // Report type code of a flat source number.
    function automatic logic [1:0] src_type(input int src);
        int t;
        t = src % 3;
        return t[1:0] + 2'd1;
    endfunction

endpackage

// File: rtl/asynfifo_err_report_arbiter_if.sv
// ---------------------------------------------------------------------------
// asynfifo_err_report_arbiter_if
// Valid/ready report channel toward the management/state-report path.
//   o_report_valid  : payload valid (driven by the arbiter)
//   i_report_ready  : consumer accepts the payload
//   ov_report_port  : source port (0 = host, 1..8 = p0..p7)
//   ov_report_type  : 1 = rx overflow, 2 = rx underflow, 3 = tx overflow
//   ov_report_count : events accumulated since the source was last reported
// ---------------------------------------------------------------------------
interface asynfifo_err_report_arbiter_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 o_report_valid;
    logic                 i_report_ready;
    logic [3:0]           ov_report_port;
    logic [1:0]           ov_report_type;
    logic [CNT_WIDTH-1:0] ov_report_count;

    modport master (
        output o_report_valid,
        output ov_report_port,
        output ov_report_type,
        output ov_report_count,
        input  i_report_ready
    );

    modport slave (
        input  o_report_valid,
        input  ov_report_port,
        input  ov_report_type,
        input  ov_report_count,
        output i_report_ready
    );
endinterface

// File: rtl/asynfifo_err_report_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: grants the first requester at or after
// i_ptr, wrapping N-1 -> 0.
//   i_req     : request vector
//   i_ptr     : highest-priority index this cycle (expected < N)
//   o_gnt     : one-hot grant (all zero when nothing requests)
//   o_idx     : binary index of the granted requester
//   o_any_req : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N     = 27,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any_req
);

    logic           found;
    logic [IDX_W:0] cand;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            // One extra bit keeps ptr + i from overflowing before the wrap.
            cand = {1'b0, i_ptr} + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(N)) begin
                cand = cand - (IDX_W + 1)'(N);
            end
            if (!found && i_req[cand[IDX_W-1:0]]) begin
                found                  = 1'b1;
                o_gnt[cand[IDX_W-1:0]] = 1'b1;
                o_idx                  = cand[IDX_W-1:0];
            end
        end
    end

    assign o_any_req = |i_req;

endmodule

// File: rtl/asynfifo_err_report_arbiter.sv
// ---------------------------------------------------------------------------
// asynfifo_err_report_arbiter
// Counts per-port async-FIFO error pulses in saturating per-(port, type)
// counters and reports them one source at a time, in round-robin order,
// over a valid/ready channel so software can tell which FIFO failed.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   iv_rx_overflow_pulse  : rx FIFO overflow pulses, one bit per port
//   iv_rx_underflow_pulse : rx FIFO underflow pulses, one bit per port
//   iv_tx_overflow_pulse  : tx FIFO overflow pulses, one bit per port
//   i_clear               : synchronous clear of every counter
//   rpt                   : report channel (valid/ready + port/type/count)
//   ov_pending            : bit n set while any counter of port n is non-zero
// ---------------------------------------------------------------------------
module asynfifo_err_report_arbiter #(
    parameter int PORT_NUM  = asynfifo_err_report_arbiter_pkg::PORT_NUM,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [PORT_NUM-1:0]           iv_rx_overflow_pulse,
    input  logic [PORT_NUM-1:0]           iv_rx_underflow_pulse,
    input  logic [PORT_NUM-1:0]           iv_tx_overflow_pulse,
    input  logic                          i_clear,
    asynfifo_err_report_arbiter_if.master rpt,
    output logic [PORT_NUM-1:0]           ov_pending
);
    import asynfifo_err_report_arbiter_pkg::*;

    localparam int N_SRC = 3 * PORT_NUM;
    localparam int IDX_W = $clog2(N_SRC);

    logic [N_SRC-1:0]     pulse_v;
    logic [N_SRC-1:0]     req_v;
    logic [N_SRC-1:0]     snap_v;
    logic [N_SRC-1:0]     gnt_oh;
    logic [CNT_WIDTH-1:0] cnt_v [N_SRC];
    logic [IDX_W-1:0]     gnt_idx;
    logic                 any_req;

    rpt_state_e           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [3:0]           port_q, port_d;
    logic [1:0]           type_q, type_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Flatten the three pulse buses into source order port*3 + (type-1).
    for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
        assign pulse_v[3*p + int'(ERR_TYPE_RX_OVF) - 1] = iv_rx_overflow_pulse[p];
        assign pulse_v[3*p + int'(ERR_TYPE_RX_UDF) - 1] = iv_rx_underflow_pulse[p];
        assign pulse_v[3*p + int'(ERR_TYPE_TX_OVF) - 1] = iv_tx_overflow_pulse[p];
        assign ov_pending[p] = |req_v[3*p +: 3];
    end

    for (genvar s = 0; s < N_SRC; s++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

        // Clear beats snapshot beats increment; a pulse landing on the
        // snapshot cycle restarts the count at 1 so it is not lost.
        always_comb begin
            cnt_d = cnt_q;
            if (i_clear) begin
                cnt_d = '0;
            end else if (snap_v[s]) begin
                cnt_d = CNT_WIDTH'(pulse_v[s]);
            end else if (pulse_v[s] && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_v[s] = cnt_q;
        assign req_v[s] = |cnt_q;
    end

    rr_arbiter #(
        .N (N_SRC)
    ) u_rr_arbiter (
        .i_req     (req_v),
        .i_ptr     (ptr_q),
        .o_gnt     (gnt_oh),
        .o_idx     (gnt_idx),
        .o_any_req (any_req)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        port_d  = port_q;
        type_d  = type_q;
        count_d = count_q;
        snap_v  = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_REPORT;
                    gidx_d  = gnt_idx;
                    port_d  = src_port(int'(gnt_idx));
                    type_d  = src_type(int'(gnt_idx));
                    count_d = cnt_v[gnt_idx];
                    snap_v  = gnt_oh;
                end
            end
            ST_REPORT: begin
                // Pointer moves past the winner only once the report is taken.
                if (rpt.i_report_ready) begin
                    state_d = ST_IDLE;
                    ptr_d   = (gidx_q == IDX_W'(N_SRC - 1)) ? '0 : gidx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            port_q  <= '0;
            type_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            port_q  <= port_d;
            type_q  <= type_d;
            count_q <= count_d;
        end
    end

    assign rpt.o_report_valid  = (state_q == ST_REPORT);
    assign rpt.ov_report_port  = port_q;
    assign rpt.ov_report_type  = type_q;
    assign rpt.ov_report_count = count_q;

endmodule

// File: tb/tb_asynfifo_err_report_arbiter.sv
module tb_asynfifo_err_report_arbiter;

    localparam int NP = 9;
    localparam int NS = 3 * NP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NP-1:0] rx_ovf, rx_udf, tx_ovf;
    logic          clr, rdy;
    logic [NP-1:0] pend, pend_s;

    asynfifo_err_report_arbiter_if #(.CNT_WIDTH(16)) rif ();
    asynfifo_err_report_arbiter_if #(.CNT_WIDTH(4))  sif ();

    assign rif.i_report_ready = rdy;
    assign sif.i_report_ready = rdy;

    always #5 clk = ~clk;

    asynfifo_err_report_arbiter #(.PORT_NUM(NP), .CNT_WIDTH(16)) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .iv_rx_overflow_pulse  (rx_ovf),
        .iv_rx_underflow_pulse (rx_udf),
        .iv_tx_overflow_pulse  (tx_ovf),
        .i_clear               (clr),
        .rpt                   (rif),
        .ov_pending            (pend)
    );

    asynfifo_err_report_arbiter #(.PORT_NUM(NP), .CNT_WIDTH(4)) dut_s (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .iv_rx_overflow_pulse  (rx_ovf),
        .iv_rx_underflow_pulse (rx_udf),
        .iv_tx_overflow_pulse  (tx_ovf),
        .i_clear               (clr),
        .rpt                   (sif),
        .ov_pending            (pend_s)
    );

    // {valid, port, type, count}
    logic [22:0] r16;
    logic [10:0] r4;
    assign r16 = {rif.o_report_valid, rif.ov_report_port, rif.ov_report_type, rif.ov_report_count};
    assign r4  = {sif.o_report_valid, sif.ov_report_port, sif.ov_report_type, sif.ov_report_count};

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: unbounded event tally per source since its last
    // snapshot; each DUT reports that tally clipped to its counter range.
    int ev [NS];
    bit m_busy;
    int m_ptr, m_g, m_port, m_type, m_cnt;

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) ev[s] = 0;
        m_busy = 1'b0;
        m_ptr = 0; m_g = 0; m_port = 0; m_type = 0; m_cnt = 0;
    endfunction

    function automatic void model_step();
        int snap;
        int s;
        bit p;
        snap = -1;
        if (!m_busy) begin
            for (int k = 0; k < NS; k++) begin
                s = (m_ptr + k) % NS;
                if (snap < 0 && ev[s] > 0) snap = s;
            end
            if (snap >= 0) begin
                m_busy = 1'b1;
                m_g    = snap;
                m_port = snap / 3;
                m_type = snap % 3 + 1;
                m_cnt  = ev[snap];
            end
        end else if (rdy) begin
            m_busy = 1'b0;
            m_ptr  = (m_g + 1) % NS;
        end
        for (int j = 0; j < NS; j++) begin
            p = (j % 3 == 0) ? rx_ovf[j/3] : (j % 3 == 1) ? rx_udf[j/3] : tx_ovf[j/3];
            if (clr)            ev[j] = 0;
            else if (j == snap) ev[j] = p ? 1 : 0;
            else                ev[j] = ev[j] + (p ? 1 : 0);
        end
    endfunction

    function automatic logic [NP-1:0] m_pend();
        logic [NP-1:0] v;
        v = '0;
        for (int p = 0; p < NP; p++) v[p] = (ev[3*p] + ev[3*p+1] + ev[3*p+2]) != 0;
        return v;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Drive one cycle of inputs from a falling edge, advance the model on the
    // rising edge, and return at the next falling edge.
    task automatic cycle(input logic [NP-1:0] a, input logic [NP-1:0] b,
                         input logic [NP-1:0] c, input logic cl, input logic rd);
        rx_ovf = a; rx_udf = b; tx_ovf = c; clr = cl; rdy = rd;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_ovf = '0; rx_udf = '0; tx_ovf = '0; clr = 1'b0; rdy = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_chk++; if (r16 !== 23'd0) begin n_fail++; $display("FAIL reset_rpt16: got %h want 0", r16); end
        n_chk++; if (r4 !== 11'd0) begin n_fail++; $display("FAIL reset_rpt4: got %h want 0", r4); end
        n_chk++; if (pend !== '0 || pend_s !== '0) begin n_fail++; $display("FAIL reset_pending: got %h/%h want 0", pend, pend_s); end
        rst_n = 1'b1;
        cycle('0, '0, '0, 1'b0, 1'b0);
        n_chk++; if (r16 !== 23'd0) begin n_fail++; $display("FAIL reset_idle: got %h want 0", r16); end
    endtask

    task automatic test_single();
        repeat (8) cycle('0, '0, '0, 1'b0, 1'b1);
        cycle(9'h008, '0, '0, 1'b0, 1'b1);
        n_chk++; if (r16[22] !== 1'b0 || pend !== 9'h008) begin n_fail++; $display("FAIL single_t1: got valid %b pend %h want 0/008", r16[22], pend); end
        cycle('0, '0, '0, 1'b0, 1'b1);
        n_chk++; if (r16 !== {1'b1, 4'd3, 2'd1, 16'd1}) begin n_fail++; $display("FAIL single_rpt: got %h want %h", r16, {1'b1, 4'd3, 2'd1, 16'd1}); end
        n_chk++; if (pend !== 9'h000) begin n_fail++; $display("FAIL single_pend_fall: got %h want 000", pend); end
        cycle('0, '0, '0, 1'b0, 1'b1);
        n_chk++; if (r16[22] !== 1'b0) begin n_fail++; $display("FAIL single_valid_fall: got %b want 0", r16[22]); end
    endtask

    task automatic test_hold();
        repeat (5) cycle('0, '0, 9'h001, 1'b0, 1'b0);
        n_chk++; if (r16 !== {1'b1, 4'd0, 2'd3, 16'd1}) begin n_fail++; $display("FAIL hold_first: got %h want %h", r16, {1'b1, 4'd0, 2'd3, 16'd1}); end
        for (int i = 0; i < 20; i++) begin
            cycle('0, '0, '0, 1'b0, 1'b0);
            n_chk++; if (r16 !== {1'b1, 4'd0, 2'd3, 16'd1} || pend[0] !== 1'b1) begin
                n_fail++; $display("FAIL hold_stable: cycle %0d got %h pend %h want %h", i, r16, pend, {1'b1, 4'd0, 2'd3, 16'd1});
            end
        end
        cycle('0, '0, '0, 1'b0, 1'b1);
        n_chk++; if (r16[22] !== 1'b0) begin n_fail++; $display("FAIL hold_accept: got valid %b want 0", r16[22]); end
        cycle('0, '0, '0, 1'b0, 1'b1);
        n_chk++; if (r16 !== {1'b1, 4'd0, 2'd3, 16'd4}) begin n_fail++; $display("FAIL hold_second: got %h want %h", r16, {1'b1, 4'd0, 2'd3, 16'd4}); end
        cycle('0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_rr_order();
        logic [22:0] exp [3];
        exp[0] = {1'b1, 4'd1, 2'd1, 16'd1};
        exp[1] = {1'b1, 4'd1, 2'd2, 16'd1};
        exp[2] = {1'b1, 4'd8, 2'd3, 16'd1};
        cycle(9'h002, 9'h002, 9'h100, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle('0, '0, '0, 1'b0, 1'b1);
            if (i % 2 == 0) begin
                n_chk++; if (r16 !== exp[i/2]) begin n_fail++; $display("FAIL rr_order_%0d: got %h want %h", i/2, r16, exp[i/2]); end
            end else begin
                n_chk++; if (r16[22] !== 1'b0) begin n_fail++; $display("FAIL rr_gap_%0d: got valid %b want 0", i/2, r16[22]); end
            end
        end
        // Pointer must now sit at 0: source 0 beats source 26.
        cycle(9'h001, '0, 9'h100, 1'b0, 1'b1);
        cycle('0, '0, '0, 1'b0, 1'b1);
        n_chk++; if (r16 !== {1'b1, 4'd0, 2'd1, 16'd1}) begin n_fail++; $display("FAIL rr_wrap_first: got %h want %h", r16, {1'b1, 4'd0, 2'd1, 16'd1}); end
        cycle('0, '0, '0, 1'b0, 1'b1);
        cycle('0, '0, '0, 1'b0, 1'b1);
        n_chk++; if (r16 !== {1'b1, 4'd8, 2'd3, 16'd1}) begin n_fail++; $display("FAIL rr_wrap_second: got %h want %h", r16, {1'b1, 4'd8, 2'd3, 16'd1}); end
        cycle('0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_collision();
        cycle(9'h020, '0, '0, 1'b0, 1'b0);
        cycle('0, '0, '0, 1'b0, 1'b0);
        n_chk++; if (r16 !== {1'b1, 4'd5, 2'd1, 16'd1}) begin n_fail++; $display("FAIL coll_blocker: got %h want %h", r16, {1'b1, 4'd5, 2'd1, 16'd1}); end
        cycle('0, 9'h004, '0, 1'b0, 1'b0);
        cycle('0, 9'h004, '0, 1'b0, 1'b0);
        cycle('0, '0, '0, 1'b0, 1'b1);
        cycle('0, 9'h004, '0, 1'b0, 1'b1);
        n_chk++; if (r16 !== {1'b1, 4'd2, 2'd2, 16'd2}) begin n_fail++; $display("FAIL coll_old_count: got %h want %h", r16, {1'b1, 4'd2, 2'd2, 16'd2}); end
        cycle('0, '0, '0, 1'b0, 1'b1);
        cycle('0, '0, '0, 1'b0, 1'b1);
        n_chk++; if (r16 !== {1'b1, 4'd2, 2'd2, 16'd1}) begin n_fail++; $display("FAIL coll_followup: got %h want %h", r16, {1'b1, 4'd2, 2'd2, 16'd1}); end
        cycle('0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_saturate();
        cycle('0, '0, 9'h040, 1'b0, 1'b0);
        cycle('0, '0, '0, 1'b0, 1'b0);
        n_chk++; if (r4 !== {1'b1, 4'd6, 2'd3, 4'd1}) begin n_fail++; $display("FAIL sat_blocker: got %h want %h", r4, {1'b1, 4'd6, 2'd3, 4'd1}); end
        repeat (20) cycle('0, '0, 9'h002, 1'b0, 1'b0);
        n_chk++; if (pend_s !== 9'h002) begin n_fail++; $display("FAIL sat_pend: got %h want 002", pend_s); end
        cycle('0, '0, '0, 1'b0, 1'b1);
        cycle('0, '0, '0, 1'b0, 1'b1);
        n_chk++; if (r4 !== {1'b1, 4'd1, 2'd3, 4'd15}) begin n_fail++; $display("FAIL sat_count4: got %h want %h", r4, {1'b1, 4'd1, 2'd3, 4'd15}); end
        n_chk++; if (r16 !== {1'b1, 4'd1, 2'd3, 16'd20}) begin n_fail++; $display("FAIL sat_count16: got %h want %h", r16, {1'b1, 4'd1, 2'd3, 16'd20}); end
        cycle('0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_clear();
        cycle(9'h010, '0, '0, 1'b0, 1'b0);
        cycle('0, '0, '0, 1'b0, 1'b0);
        cycle(9'h001, 9'h110, '0, 1'b0, 1'b0);
        n_chk++; if (pend !== 9'h111) begin n_fail++; $display("FAIL clr_pend_before: got %h want 111", pend); end
        cycle('0, '0, '0, 1'b1, 1'b0);
        n_chk++; if (r16 !== {1'b1, 4'd4, 2'd1, 16'd1}) begin n_fail++; $display("FAIL clr_inflight: got %h want %h", r16, {1'b1, 4'd4, 2'd1, 16'd1}); end
        n_chk++; if (pend !== 9'h000) begin n_fail++; $display("FAIL clr_pend_after: got %h want 000", pend); end
        for (int i = 0; i < 5; i++) begin
            cycle('0, '0, '0, 1'b0, 1'b1);
            n_chk++; if (r16[22] !== 1'b0 || pend !== 9'h000) begin n_fail++; $display("FAIL clr_quiet: cycle %0d got valid %b pend %h want 0/000", i, r16[22], pend); end
        end
    endtask

    task automatic test_async_reset();
        cycle('0, 9'h080, 9'h001, 1'b0, 1'b0);
        cycle('0, '0, '0, 1'b0, 1'b0);
        n_chk++; if (r16[22] !== 1'b1) begin n_fail++; $display("FAIL arst_setup: got valid %b want 1", r16[22]); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (r16 !== 23'd0 || r4 !== 11'd0) begin n_fail++; $display("FAIL arst_outputs: got %h/%h want 0", r16, r4); end
        n_chk++; if (pend !== '0 || pend_s !== '0) begin n_fail++; $display("FAIL arst_pending: got %h/%h want 0", pend, pend_s); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle('0, '0, '0, 1'b0, 1'b1);
        n_chk++; if (r16 !== 23'd0) begin n_fail++; $display("FAIL arst_after: got %h want 0", r16); end
    endtask

    task automatic test_random();
        logic [NP-1:0] a, b, c;
        logic cl, rd;
        int mode;
        logic [22:0] e16;
        logic [10:0] e4;
        for (int i = 0; i < 900; i++) begin
            mode = (i / 60) % 3;
            if (mode == 1) begin
                a = NP'($urandom); b = NP'($urandom); c = NP'($urandom);
                rd = ($urandom_range(0, 99) < 5);
            end else begin
                a = NP'($urandom & $urandom & $urandom);
                b = NP'($urandom & $urandom & $urandom);
                c = NP'($urandom & $urandom & $urandom);
                rd = ($urandom_range(0, 99) < ((mode == 0) ? 80 : 50));
            end
            cl = ($urandom_range(0, 63) == 0);
            cycle(a, b, c, cl, rd);
            n_chk++; if (r16[22] !== m_busy || r4[10] !== m_busy) begin n_fail++; $display("FAIL rand_valid: cycle %0d got %b/%b want %b", i, r16[22], r4[10], m_busy); end
            if (m_busy) begin
                e16 = {1'b1, 4'(m_port), 2'(m_type), 16'(sat(m_cnt, 65535))};
                e4  = {1'b1, 4'(m_port), 2'(m_type), 4'(sat(m_cnt, 15))};
                n_chk++; if (r16 !== e16) begin n_fail++; $display("FAIL rand_rpt16: cycle %0d got %h want %h", i, r16, e16); end
                n_chk++; if (r4 !== e4) begin n_fail++; $display("FAIL rand_rpt4: cycle %0d got %h want %h", i, r4, e4); end
            end
            n_chk++; if (pend !== m_pend() || pend_s !== m_pend()) begin n_fail++; $display("FAIL rand_pend: cycle %0d got %h/%h want %h", i, pend, pend_s, m_pend()); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_rr_order();
        test_collision();
        test_saturate();
        test_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/asynfifo_err_report_arbiter.md
Name: asynfifo_err_report_arbiter

Overview:
- Collects per-port async-FIFO error pulses (rx overflow, rx underflow, tx overflow) for the host port plus ports p0..p7.
- Pulses are already synchronized to i_clk.
- Accumulates events per (port, type) in saturating counters.
- Round-robin arbitrates the 27 sources onto one valid/ready report channel toward the management/state-report path, so the CPU sees which port and FIFO failed, not just an aggregate LED.

Parameters:
- PORT_NUM, 9: sources per type; index 0 = host, 1..8 = p0..p7.
- CNT_WIDTH, 16: width of each per-source event counter and of the reported count.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- iv_rx_overflow_pulse  input  PORT_NUM  single-cycle rx FIFO overflow pulses, synchronized to i_clk
- iv_rx_underflow_pulse  input  PORT_NUM  single-cycle rx FIFO underflow pulses
- iv_tx_overflow_pulse  input  PORT_NUM  single-cycle tx FIFO overflow pulses
- i_clear  input  1  synchronous clear of all counters
- o_report_valid  output  1  report payload valid
- i_report_ready  input  1  consumer accepts the report
- ov_report_port  output  4  source port index (0 = host, 1..8 = p0..p7)
- ov_report_type  output  2  1 = rx_overflow, 2 = rx_underflow, 3 = tx_overflow
- ov_report_count  output  CNT_WIDTH  events accumulated since this source was last reported
- ov_pending  output  PORT_NUM  bit n high if any counter of port n is non-zero

Behaviour:
- Reset: all outputs 0, all counters 0, RR pointer 0, FSM in IDLE.
- Source index s = port*3 + (type-1), range 0..26.
- Counter update per cycle:
  - pulse high: counter + 1, saturating at all-ones. No wrap; further pulses are dropped.
  - Source snapshotted this cycle: counter becomes 0, or 1 if its pulse is also high that cycle. No event is lost.
  - i_clear high: counter becomes 0 and overrides both pulse and snapshot.
- FSM, two states:
  - IDLE: if any counter is non-zero, grant the first non-zero source at or after the RR pointer, wrapping 26 -> 0. Register port, type and count into the outputs, snapshot-clear that counter, and go to REPORT. o_report_valid rises on that edge. If no counter is non-zero, stay in IDLE.
  - REPORT: hold o_report_valid and keep the payload stable until i_report_ready is high on a clock edge. On that edge drop valid, set pointer = granted+1 (mod 27) and return to IDLE.
- Latency: pulse at cycle t -> counter non-zero at t+1 -> o_report_valid high at t+2.
- Throughput: at most one report per 2 cycles.
- ready held high with a continuous backlog: valid toggles 1,0,1,0…
- i_report_ready while in IDLE is ignored.
- i_clear during REPORT: the in-flight report is not aborted and its payload is unchanged. Counters clear.
- Simultaneous pulses on many sources: each source accumulates independently. Reports follow RR order from the pointer.
- ov_pending is combinational from the counters, OR of the port's three counters != 0. It excludes a report currently in flight.
- Reset asserted mid-REPORT: valid drops immediately (async), and all state returns to reset values.

Decomposition:
- Shared package holds:
  - PORT_NUM
  - ERR_TYPE_RX_OVF=2'd1, ERR_TYPE_RX_UDF=2'd2, ERR_TYPE_TX_OVF=2'd3
  - SRC_NUM = 3*PORT_NUM
  - FSM state encodings IDLE/REPORT
- Sub-module rr_arbiter: parameter N. Inputs are a request vector and the pointer. Outputs are a one-hot grant, a binary index and any_req. Purely combinational, reusable by other report paths.
- Counters and FSM live in the top module as a generate loop over SRC_NUM.

Test Plan:
- Single iv_rx_overflow_pulse[3] at cycle 10, i_report_ready=1 → o_report_valid at cycle 12 with port=3, type=1, count=1. Valid falls at cycle 13 and ov_pending[3] falls at 12.
- 5 pulses on iv_tx_overflow_pulse[0] with i_report_ready=0 → report port=0, type=3, count=1 stays stable while ready is held low for 20 cycles; the counter then holds 4. Raising ready gives a second report with count=4.
- Same-cycle pulses on rx_overflow[1], rx_underflow[1] and tx_overflow[8] with ready=1 → reports in order (1,1), (1,2), (8,3), each count=1, then the pointer wraps to 0.
- Pulse on the source being snapshotted in the same cycle as the grant → the current report has the old count and a follow-up report has count=1.
- CNT_WIDTH=4: 20 pulses on one source with ready=0 beforehand → report count=15 (saturated), no wrap.
- i_clear asserted while 3 sources are pending and one report is in flight → the in-flight report completes unchanged, with no further reports and ov_pending=0. Async reset mid-REPORT → valid=0 immediately and all outputs are 0.
